// File: rtl/imm_split_if.sv
`default_nettype none
// ============================================================================
//  Module      : imm_split_if
//  Description : Valid/ready bundle for the immediate splitter. The constant
//                source drives in_*, the instruction builder consumes out_*.
//                "master" is the environment side, "slave" is the splitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imm_split_if #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 12
);
   localparam int UIMM_W = XLEN - IMM_W;

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_kind;
   logic [UIMM_W-1:0] out_imm;
   logic              out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_kind, out_imm, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_kind, out_imm, out_last
   );
endinterface
`default_nettype wire

// File: rtl/imm_split.sv
`default_nettype none
// ============================================================================
//  Module      : imm_split
//  Description : Splits a 32-bit constant into immediate beats that a 12-bit
//                sign-extending decoder reassembles exactly: one I-type beat
//                when the value fits, otherwise a U-type beat (upper field,
//                rounded for the sign of the low part) optionally followed by
//                an I-type beat. Outputs are registered.
//                Optional macro IMM_SPLIT_SELFCHECK_EN adds a chk_err output
//                that reassembles each emitted sequence and flags mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_split #(
   parameter int XLEN  = 32,
   parameter int IMM_W = 12
) (
   input  wire         clk,
   input  wire         rst,
   imm_split_if.slave  bus
`ifdef IMM_SPLIT_SELFCHECK_EN
   ,
   output logic        chk_err
`endif
);
   // The I-beat immediate is sign-extended into the U-field width, so the
   // U field must be at least as wide as the I field.
   localparam int UIMM_W = XLEN - IMM_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HI   = 2'd1;
   localparam logic [1:0] S_LO   = 2'd2;

   function automatic logic [UIMM_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
      return {{(UIMM_W-IMM_W){v[IMM_W-1]}}, v};
   endfunction

   logic [1:0]        r_state;
   logic [IMM_W-1:0]  r_lo;
   logic              r_out_valid;
   logic              r_out_kind;
   logic [UIMM_W-1:0] r_out_imm;
   logic              r_out_last;

   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_in_ready;
   logic [XLEN-IMM_W:0] w_upper;
   logic              w_fits;
   logic [IMM_W-1:0]  w_lo;
   logic [UIMM_W-1:0] w_hi;

   assign w_out_xfer = r_out_valid & bus.out_ready;
   // Accept when idle, or when the final beat leaves this cycle (no bubble).
   assign w_in_ready = (r_state == S_IDLE) | (w_out_xfer & r_out_last);
   assign w_in_xfer  = bus.in_valid & w_in_ready;

   // Fits when bits [XLEN-1:IMM_W-1] are a pure sign extension.
   assign w_upper = bus.in_data[XLEN-1:IMM_W-1];
   assign w_fits  = (&w_upper) | ~(|w_upper);
   assign w_lo    = bus.in_data[IMM_W-1:0];
   // Adding 2^(IMM_W-1) before shifting only carries into the upper field
   // through bit IMM_W-1, so the rounding is an increment by that bit.
   assign w_hi    = bus.in_data[XLEN-1:IMM_W] + UIMM_W'(bus.in_data[IMM_W-1]);

   // Sequencer: load the first beat on accept, then step HI -> LO -> IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_lo        <= '0;
         r_out_valid <= 1'b0;
         r_out_kind  <= 1'b0;
         r_out_imm   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_in_xfer) begin
         r_lo        <= w_lo;
         r_out_valid <= 1'b1;
         if (w_fits) begin
            r_state    <= S_LO;
            r_out_kind <= 1'b0;
            r_out_imm  <= sext_imm(w_lo);
            r_out_last <= 1'b1;
         end else begin
            r_state    <= S_HI;
            r_out_kind <= 1'b1;
            r_out_imm  <= w_hi;
            r_out_last <= (w_lo == '0);
         end
      end else if (w_out_xfer) begin
         if ((r_state == S_HI) && !r_out_last) begin
            r_state    <= S_LO;
            r_out_kind <= 1'b0;
            r_out_imm  <= sext_imm(r_lo);
            r_out_last <= 1'b1;
         end else begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_kind  = r_out_kind;
   assign bus.out_imm   = r_out_imm;
   assign bus.out_last  = r_out_last;

`ifdef IMM_SPLIT_SELFCHECK_EN
   logic [XLEN-1:0] r_x;
   logic [XLEN-1:0] r_acc;
   logic            r_chk_err;
   logic [XLEN-1:0] w_beat_val;
   logic [XLEN-1:0] w_acc_next;

   // Contribution of the beat currently on the bus, as the decoder sees it.
   assign w_beat_val = r_out_kind ? {r_out_imm, {IMM_W{1'b0}}}
                                  : {{(XLEN-IMM_W){r_out_imm[IMM_W-1]}}, r_out_imm[IMM_W-1:0]};
   assign w_acc_next = r_acc + w_beat_val;

   // Reassemble each sequence and flag (sticky) any mismatch at its last beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x       <= '0;
         r_acc     <= '0;
         r_chk_err <= 1'b0;
      end else begin
         if (w_out_xfer && r_out_last && (w_acc_next != r_x))
            r_chk_err <= 1'b1;
         if (w_in_xfer) begin
            r_x   <= bus.in_data;
            r_acc <= '0;
         end else if (w_out_xfer) begin
            r_acc <= w_acc_next;
         end
      end
   end

   assign chk_err = r_chk_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_imm_split.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_split
//  Description : Directed bench for imm_split: table of single-value vectors
//                plus hand-written stream, stall, same-cycle-accept and
//                mid-sequence reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_split;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   imm_split_if #(.XLEN(32), .IMM_W(12)) bus ();

`ifdef IMM_SPLIT_SELFCHECK_EN
   logic chk_err;
`endif

   imm_split #(.XLEN(32), .IMM_W(12)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus)
`ifdef IMM_SPLIT_SELFCHECK_EN
      ,
      .chk_err (chk_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      int          nb;    // 1 or 2 beats
      logic        k0;    // kind of first beat
      logic [19:0] i0;    // first beat immediate
      logic [19:0] i1;    // second (I-type) beat immediate when nb==2
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One value with out_ready held high; checks every beat and the idle after.
   task automatic run_vec(input int n);
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = vecs[n].x;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", n), 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      check($sformatf("v%0d_b0_valid", n), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_b0_kind", n),  32'(bus.out_kind),  32'(vecs[n].k0));
      check($sformatf("v%0d_b0_imm", n),   32'(bus.out_imm),   32'(vecs[n].i0));
      check($sformatf("v%0d_b0_last", n),  32'(bus.out_last),  32'(vecs[n].nb == 1));
      if (vecs[n].nb == 2) begin
         @(negedge clk);
         check($sformatf("v%0d_b1_valid", n), 32'(bus.out_valid), 32'd1);
         check($sformatf("v%0d_b1_kind", n),  32'(bus.out_kind),  32'd0);
         check($sformatf("v%0d_b1_imm", n),   32'(bus.out_imm),   32'(vecs[n].i1));
         check($sformatf("v%0d_b1_last", n),  32'(bus.out_last),  32'd1);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle", n), 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] xs [5];
      logic        ek [6];
      logic [19:0] ei [6];
      logic        el [6];
      int ia, ob, cyc, first_beat;

      checks   = 0;
      failures = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      vecs[0]  = '{32'd10,         1, 1'b0, 20'h0000A, 20'h00000};
      vecs[1]  = '{32'hFFFFF7FF,   2, 1'b1, 20'hFFFFF, 20'h007FF};
      vecs[2]  = '{32'h12345000,   1, 1'b1, 20'h12345, 20'h00000};
      vecs[3]  = '{32'h000007FF,   1, 1'b0, 20'h007FF, 20'h00000};
      vecs[4]  = '{32'h00000800,   2, 1'b1, 20'h00001, 20'hFF800};
      vecs[5]  = '{32'hFFFFF800,   1, 1'b0, 20'hFF800, 20'h00000};
      vecs[6]  = '{32'h7FFFF800,   2, 1'b1, 20'h80000, 20'hFF800};
      vecs[7]  = '{32'h00000000,   1, 1'b0, 20'h00000, 20'h00000};
      vecs[8]  = '{32'hFFFFFFFF,   1, 1'b0, 20'hFFFFF, 20'h00000};
      vecs[9]  = '{32'h80000000,   1, 1'b1, 20'h80000, 20'h00000};
      vecs[10] = '{32'h12345678,   2, 1'b1, 20'h12345, 20'h00678};
      vecs[11] = '{32'hDEADBEEF,   2, 1'b1, 20'hDEADC, 20'hFFEEF};
      vecs[12] = '{32'hFFFFF000,   1, 1'b1, 20'hFFFFF, 20'h00000};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_kind",  32'(bus.out_kind),  32'd0);
      check("rst_out_imm",   32'(bus.out_imm),   32'd0);
      check("rst_out_last",  32'(bus.out_last),  32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      #1 rst = 1'b0;

      for (int n = 0; n < 13; n++) run_vec(n);

      // Back-to-back stream with out_ready held high
      xs[0] = 32'd5; xs[1] = 32'hFFFFFFFB; xs[2] = 32'd1337;
      xs[3] = 32'hFFFFF81D; xs[4] = 32'h00000800;
      ek[0] = 1'b0; ei[0] = 20'h00005; el[0] = 1'b1;
      ek[1] = 1'b0; ei[1] = 20'hFFFFB; el[1] = 1'b1;
      ek[2] = 1'b0; ei[2] = 20'h00539; el[2] = 1'b1;
      ek[3] = 1'b0; ei[3] = 20'hFF81D; el[3] = 1'b1;
      ek[4] = 1'b1; ei[4] = 20'h00001; el[4] = 1'b0;
      ek[5] = 1'b0; ei[5] = 20'hFF800; el[5] = 1'b1;
      ia = 0; ob = 0; cyc = 0; first_beat = -1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      while (ob < 6 && cyc < 40) begin
         bus.in_valid = (ia < 5);
         bus.in_data  = (ia < 5) ? xs[ia] : 32'd0;
         @(negedge clk);
         if (bus.out_valid) begin
            check($sformatf("s%0d_kind", ob), 32'(bus.out_kind), 32'(ek[ob]));
            check($sformatf("s%0d_imm", ob),  32'(bus.out_imm),  32'(ei[ob]));
            check($sformatf("s%0d_last", ob), 32'(bus.out_last), 32'(el[ob]));
            if (ob == 0) first_beat = cyc;
            ob++;
         end
         if (bus.in_valid && bus.in_ready) ia++;
         @(posedge clk); #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      check("stream_beats",      32'(ob),               32'd6);
      check("stream_first_beat", 32'(first_beat),       32'd1);
      check("stream_no_bubble",  32'(cyc - first_beat), 32'd6);
`ifdef IMM_SPLIT_SELFCHECK_EN
      check("stream_chk_err", 32'(chk_err), 32'd0);
`endif

      // Same-cycle accept: next value taken while the single U beat leaves
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h12345000;
      @(posedge clk); #1;
      bus.in_data  = 32'd10;
      @(negedge clk);
      check("sc_u_imm",    32'(bus.out_imm),  32'h12345);
      check("sc_u_last",   32'(bus.out_last), 32'd1);
      check("sc_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      check("sc_next_valid", 32'(bus.out_valid), 32'd1);
      check("sc_next_kind",  32'(bus.out_kind),  32'd0);
      check("sc_next_imm",   32'(bus.out_imm),   32'h0000A);
      @(negedge clk);
      check("sc_idle", 32'(bus.out_valid), 32'd0);

      // Stall: HI beat of 0x7FFFF800 held for 3 cycles
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h7FFFF800;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check($sformatf("st%0d_valid", s),    32'(bus.out_valid), 32'd1);
         check($sformatf("st%0d_kind", s),     32'(bus.out_kind),  32'd1);
         check($sformatf("st%0d_imm", s),      32'(bus.out_imm),   32'h80000);
         check($sformatf("st%0d_last", s),     32'(bus.out_last),  32'd0);
         check($sformatf("st%0d_in_ready", s), 32'(bus.in_ready),  32'd0);
      end
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check("st_lo_kind", 32'(bus.out_kind), 32'd0);
      check("st_lo_imm",  32'(bus.out_imm),  32'hFF800);
      check("st_lo_last", 32'(bus.out_last), 32'd1);
      @(negedge clk);
      check("st_idle", 32'(bus.out_valid), 32'd0);
`ifdef IMM_SPLIT_SELFCHECK_EN
      check("st_chk_err", 32'(chk_err), 32'd0);
`endif

      // Asynchronous reset during the HI beat of 0xFFFFF7FF
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hFFFFF7FF;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      check("ar_hi_valid", 32'(bus.out_valid), 32'd1);
      check("ar_hi_kind",  32'(bus.out_kind),  32'd1);
      #1 rst = 1'b1;
      #1;
      check("ar_valid_async", 32'(bus.out_valid), 32'd0);
      check("ar_in_ready",    32'(bus.in_ready),  32'd1);
      check("ar_imm",         32'(bus.out_imm),   32'd0);
      @(negedge clk);
      #1;
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         check($sformatf("ar_post%0d_valid", r), 32'(bus.out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/imm_split.md
Name: imm_split

Overview:
- Inverse of the 12-bit immediate sign extender: takes 32-bit constants and encodes each as a sequence of immediate fields that the sign-extending decode path reconstructs exactly.
- A value that fits in a signed 12-bit immediate becomes one I-type beat (ADDI-style).
- Any other value becomes a U-type beat (LUI-style, upper 20 bits), optionally followed by an I-type beat.
- Sits between the constant source (assembler/loader datapath) and the instruction builder. Valid/ready on both sides.

Parameters:
- XLEN, 32, input value width.
- IMM_W, 12, I-type immediate width. The U-type field width is UIMM_W = XLEN-IMM_W, which is 20 by default.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input value valid.
- in_ready  out  1  block can accept a value this cycle.
- in_data  in  XLEN  constant to encode.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_kind  out  1  0 = I-type beat, 1 = U-type beat.
- out_imm  out  UIMM_W  immediate field. For I-type, bits [IMM_W-1:0] hold the value and the upper bits are sign-extended from bit IMM_W-1.
- out_last  out  1  final beat for the current value.

Behaviour:
- Handshakes:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- States:
  - IDLE: nothing pending.
  - HI: presenting the U-type beat.
  - LO: presenting the I-type beat.
- Reset (async): state=IDLE, out_valid=0, out_kind=0, out_imm=0, out_last=0, internal value register=0. Reset asserted mid-sequence discards the pending value; no partial beat survives.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This allows back-to-back values with no bubble.
- On accept, with x = in_data:
  - fits = (x[XLEN-1:IMM_W-1] all 0s or all 1s).
  - lo = x[IMM_W-1:0].
  - hi = (x + 2^(IMM_W-1)) >> IMM_W, truncated to UIMM_W bits (wrap is intended).
- Next state after accept:
  - fits → LO with lo.
  - not fits → HI with hi. Record whether lo == 0.
- Latency: the first beat is valid in the cycle after input acceptance. Outputs are registered, not combinational from in_data.
- HI state: out_valid=1, out_kind=1, out_imm=hi, out_last=(lo==0).
  - On transfer with lo==0: go to IDLE, or to the new value's state if accepted in the same cycle.
  - On transfer with lo!=0: go to LO.
- LO state: out_valid=1, out_kind=0, out_imm=sext(lo), out_last=1. On transfer: go to IDLE, or to the new value's state.
- Stall: while out_valid & !out_ready, out_kind, out_imm and out_last hold stable and in_ready=0.
- Invariant: ((hi << IMM_W) + sext(lo)) mod 2^XLEN == x. A fitting value always emits exactly one I-type beat, including x=0.
- Boundaries:
  - x=0x7FF → single I beat.
  - x=0x800 → HI 0x00001, then LO 0x800 (sext = -2048).
  - x=0xFFFFF800 fits → single I beat.
  - hi wraps for x near 0x7FFFF800 → hi=0x80000.

Optional Feature:
- Macro: IMM_SPLIT_SELFCHECK_EN.
- When defined:
  - Add output port chk_err (1 bit, reset 0).
  - An internal accumulator clears on input accept. It adds (out_imm << IMM_W) on a U transfer and sext(out_imm[IMM_W-1:0]) on an I transfer.
  - At the out_last transfer, compare the accumulator with the latched x. chk_err is sticky-set on mismatch and cleared only by rst.
- When undefined: no port, no accumulator, no extra logic.

Test Plan:
- in_data=10, out_ready=1 → one beat: kind=0, imm=0x0000A, last=1, one cycle after accept.
- in_data=0xFFFFF7FF (-2049) → beat 1: kind=1, imm=0xFFFFF, last=0. Beat 2: kind=0, imm=0x007FF, last=1.
- in_data=0x12345000 → single beat: kind=1, imm=0x12345, last=1. Next value accepted in the same cycle (in_ready=1 during the last transfer).
- in_data=0x7FFFF800 with out_ready low for 3 cycles → beat HI 0x80000 held stable and in_ready=0 while stalled, then LO 0xFF800 (sext of 0x800), last=1.
- Stream 5, -5, 1337, -2019, 0x800 back-to-back with out_ready=1. Expected beats:
  - 5 → I 0x00005
  - -5 → I 0xFFFFB
  - 1337 → I 0x00539
  - -2019 → I 0xFF81D
  - 0x800 → U 0x00001, then I 0xFF800
  - No bubbles between values; with IMM_SPLIT_SELFCHECK_EN defined, chk_err stays 0.
- Assert rst during the HI beat of 0xFFFFF7FF → out_valid=0 immediately (asynchronously), state IDLE, and no LO beat is emitted after reset release.
